// File: rtl/fetch_unit_pkg.sv
// Shared cpu definitions used by the instruction fetch stage:
// state encoding, instruction width, PC step and the default reset PC.
package fetch_unit_pkg;

    localparam int unsigned ILEN = 32;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DROP    = 2'd2,
        BLOCKED = 2'd3
    } fetch_state_e;

    // One fetched instruction together with its byte address.
    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

    // Clear the two byte-offset bits of an address.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction that decode could not take.
// Ports: clk, rst_n, clear (drop contents), push/push_pc/push_instr, pop,
//        valid/pc/instr (current entry).
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic [31:0]     push_pc,
    input  logic [ILEN-1:0] push_instr,
    input  logic            pop,
    output logic            valid,
    output logic [31:0]     pc,
    output logic [ILEN-1:0] instr
);

    fetch_pkt_t pkt_q;
    logic       valid_q;

    // clear beats push beats pop; push and pop never coincide in practice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (push) begin
            valid_q     <= 1'b1;
            pkt_q.pc    <= push_pc;
            pkt_q.instr <= push_instr;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pkt_q.pc;
    assign instr = pkt_q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory request handshake,
// branch redirect with in-flight discard, and a skid buffer toward decode.
// Ports: clk, rst_n; branch_valid/branch_taken/branch_target and stall from
//        decode; imem_req/imem_addr/imem_ready/imem_rdata to instruction
//        memory; if_valid/if_pc/if_instr to decode; flush on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_valid,
    input  logic            branch_taken,
    input  logic [31:0]     branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            flush
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     tgt_q, tgt_d;
    logic [31:0]     tgt_in;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;

    logic            redirect;
    logic            accept;
    logic            consume;
    logic            skid_push;
    logic            skid_pop;
    logic            skid_valid;
    logic [31:0]     skid_pc;
    logic [ILEN-1:0] skid_instr;

    assign redirect = branch_valid & branch_taken;
    assign flush    = redirect;
    assign tgt_in   = align_word(branch_target);
    assign accept   = imem_req & imem_ready;
    assign consume  = if_valid_q & ~stall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    // Request still outstanding: hold it and drop its data.
                    if (!accept) begin
                        state_d = DROP;
                    end
                end else if (accept && if_valid_q && stall) begin
                    state_d = BLOCKED;
                end
            end
            DROP: begin
                if (accept) begin
                    state_d = REQ;
                end
            end
            BLOCKED: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. In DROP the stale request stays up at the old pc
    // so the handshake is never withdrawn before it completes.
    always_comb begin : fsm_out
        imem_req = 1'b0;
        unique case (state_q)
            REQ, DROP: imem_req = 1'b1;
            default:   imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc_q;

    // PC and pending redirect target.
    always_comb begin : pc_next
        pc_d  = pc_q;
        tgt_d = tgt_q;
        unique case (state_q)
            REQ, DROP: begin
                if (redirect) begin
                    if (accept) begin
                        pc_d = tgt_in;
                    end else begin
                        tgt_d = tgt_in;
                    end
                end else if (accept) begin
                    pc_d = (state_q == DROP) ? tgt_q : pc_q + PC_INC;
                end
            end
            IDLE, BLOCKED: begin
                if (redirect) begin
                    pc_d = tgt_in;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            tgt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            tgt_q <= tgt_d;
        end
    end

    // Decode-facing register and skid control.
    always_comb begin : if_next
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        if (redirect) begin
            if_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if_valid_d = 1'b0;
            end
            unique case (state_q)
                REQ: begin
                    if (accept) begin
                        if (!if_valid_q || !stall) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata;
                        end else begin
                            skid_push = 1'b1;
                        end
                    end
                end
                BLOCKED: begin
                    if (!stall) begin
                        if_valid_d = skid_valid;
                        if_pc_d    = skid_pc;
                        if_instr_d = skid_instr;
                        skid_pop   = 1'b1;
                    end
                end
                default: skid_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect),
        .push       (skid_push),
        .push_pc    (pc_q),
        .push_instr (imem_rdata),
        .pop        (skid_pop),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a program-order stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bv = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] btgt = '0;
    logic        stall = 1'b0;
    logic        ready = 1'b0;

    logic        req0, req1, v0, v1, fl0, fl1;
    logic [31:0] addr0, addr1, rd0, rd1;
    logic [31:0] pc0, pc1, ins0, ins1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    assign rd0 = memf(addr0);
    assign rd1 = memf(addr1);

    fetch_unit dut0 (
        .clk(clk), .rst_n(rst_n),
        .branch_valid(bv), .branch_taken(bt), .branch_target(btgt),
        .stall(stall),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ready(ready), .imem_rdata(rd0),
        .if_valid(v0), .if_pc(pc0), .if_instr(ins0),
        .flush(fl0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .branch_valid(bv), .branch_taken(bt), .branch_target(btgt),
        .stall(stall),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ready(ready), .imem_rdata(rd1),
        .if_valid(v1), .if_pc(pc1), .if_instr(ins1),
        .flush(fl1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the bench at the first falling edge after release (DUT in IDLE).
    task automatic do_reset();
        rst_n = 1'b0;
        bv = 1'b0; bt = 1'b0; btgt = '0;
        stall = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1; stall = 1'b0;
        repeat (2) @(posedge clk);
        smp();
        n_chk++;
        if ({req0, addr0, v0, pc0, ins0} !== {1'b0, 32'h0, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset0: got req=%b addr=%h v=%b pc=%h ins=%h want 0",
                     req0, addr0, v0, pc0, ins0);
        end
        n_chk++;
        if ({req1, addr1, v1, fl0} !== {1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset1: got req=%b addr=%h v=%b fl=%b want 0/fffffff8/0/0",
                     req1, addr1, v1, fl0);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        n_chk++;
        if (req0 !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_idle: got req=%b want 0", req0);
        end
        for (int k = 1; k <= 5; k++) begin
            tick(); smp();
            e = 32'(4 * (k - 1));
            n_chk++;
            if ({req0, addr0} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got req=%b addr=%h want 1/%h",
                         k, req0, addr0, e);
            end
            if (k >= 2) begin
                e = e - 32'd4;
                n_chk++;
                if ({v0, pc0, ins0} !== {1'b1, e, memf(e)}) begin
                    n_fail++;
                    $display("FAIL seq_if%0d: got v=%b pc=%h ins=%h want 1/%h/%h",
                             k, v0, pc0, ins0, e, memf(e));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) begin tick(); smp(); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); smp();
            n_chk++;
            if ({req0, v0, pc0} !== {1'b0, 1'b1, 32'h4}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got req=%b v=%b pc=%h want 0/1/4",
                         k, req0, v0, pc0);
            end
        end
        stall = 1'b0;
        tick(); smp();
        n_chk++;
        if ({v0, pc0, ins0, req0, addr0} !== {1'b1, 32'h8, memf(32'h8), 1'b1, 32'hC}) begin
            n_fail++;
            $display("FAIL stall_skid: got v=%b pc=%h ins=%h req=%b addr=%h want 1/8/%h/1/c",
                     v0, pc0, ins0, req0, addr0, memf(32'h8));
        end
        tick(); smp();
        n_chk++;
        if ({v0, pc0, ins0} !== {1'b1, 32'hC, memf(32'hC)}) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b pc=%h ins=%h want 1/c/%h",
                     v0, pc0, ins0, memf(32'hC));
        end
    endtask

    task automatic test_drop();
        do_reset();
        repeat (3) begin tick(); smp(); end
        ready = 1'b0;
        tick(); smp();
        bv = 1'b1; bt = 1'b1; btgt = 32'h100;
        #1;
        n_chk++;
        if ({fl0, req0, addr0} !== {1'b1, 1'b1, 32'h8}) begin
            n_fail++;
            $display("FAIL drop_flush: got fl=%b req=%b addr=%h want 1/1/8",
                     fl0, req0, addr0);
        end
        tick();
        bv = 1'b0; bt = 1'b0; btgt = '0;
        for (int k = 0; k < 3; k++) begin
            smp();
            n_chk++;
            if ({req0, addr0, v0, fl0} !== {1'b1, 32'h8, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL drop_hold%0d: got req=%b addr=%h v=%b fl=%b want 1/8/0/0",
                         k, req0, addr0, v0, fl0);
            end
            tick();
        end
        ready = 1'b1;
        tick(); smp();
        n_chk++;
        if ({req0, addr0, v0} !== {1'b1, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_tgt: got req=%b addr=%h v=%b want 1/100/0",
                     req0, addr0, v0);
        end
        tick(); smp();
        n_chk++;
        if ({v0, pc0, ins0} !== {1'b1, 32'h100, memf(32'h100)}) begin
            n_fail++;
            $display("FAIL drop_if: got v=%b pc=%h ins=%h want 1/100/%h",
                     v0, pc0, ins0, memf(32'h100));
        end
    endtask

    task automatic test_redirect_blocked();
        do_reset();
        repeat (3) begin tick(); smp(); end
        stall = 1'b1;
        tick(); smp();
        bv = 1'b1; bt = 1'b1; btgt = 32'h242;
        tick();
        bv = 1'b0; bt = 1'b0; stall = 1'b0;
        smp();
        n_chk++;
        if ({v0, req0, addr0} !== {1'b0, 1'b1, 32'h240}) begin
            n_fail++;
            $display("FAIL blk_redir: got v=%b req=%b addr=%h want 0/1/240",
                     v0, req0, addr0);
        end
        tick(); smp();
        n_chk++;
        if ({v0, pc0, ins0} !== {1'b1, 32'h240, memf(32'h240)}) begin
            n_fail++;
            $display("FAIL blk_skid_empty: got v=%b pc=%h want 1/240", v0, pc0);
        end
    endtask

    task automatic test_latency();
        do_reset();
        repeat (3) begin tick(); smp(); end
        bv = 1'b1; bt = 1'b0; btgt = 32'h500;
        #1;
        n_chk++;
        if (fl0 !== 1'b0) begin
            n_fail++;
            $display("FAIL nottaken_flush: got %b want 0", fl0);
        end
        tick(); smp();
        n_chk++;
        if ({v0, pc0, addr0} !== {1'b1, 32'h8, 32'hC}) begin
            n_fail++;
            $display("FAIL nottaken_seq: got v=%b pc=%h addr=%h want 1/8/c",
                     v0, pc0, addr0);
        end
        bt = 1'b1; btgt = 32'h80;
        tick();
        bv = 1'b0; bt = 1'b0;
        smp();
        n_chk++;
        if ({v0, addr0} !== {1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL lat_t1: got v=%b addr=%h want 0/80", v0, addr0);
        end
        tick(); smp();
        n_chk++;
        if ({v0, pc0, ins0} !== {1'b1, 32'h80, memf(32'h80)}) begin
            n_fail++;
            $display("FAIL lat_t2: got v=%b pc=%h want 1/80", v0, pc0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(); smp();
            e = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            n_chk++;
            if ({req1, addr1} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL wrap%0d: got req=%b addr=%h want 1/%h",
                         k, req1, addr1, e);
            end
        end
        bv = 1'b1; bt = 1'b1; btgt = 32'h103;
        #1;
        n_chk++;
        if (fl1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_flush: got %b want 1", fl1);
        end
        tick();
        bv = 1'b0; bt = 1'b0;
        smp();
        n_chk++;
        if ({req1, addr1} !== {1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL wrap_align: got req=%b addr=%h want 1/100", req1, addr1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) begin tick(); smp(); end
        ready = 1'b0; stall = 1'b1;
        tick(); smp();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req0, addr0, v0, pc0, ins0} !== {1'b0, 32'h0, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL rst_mid: got req=%b addr=%h v=%b pc=%h ins=%h want 0",
                     req0, addr0, v0, pc0, ins0);
        end
        ready = 1'b1; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
        tick(); smp();
        n_chk++;
        if ({req0, addr0} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got req=%b addr=%h want 1/0", req0, addr0);
        end
    endtask

    // Model: decode sees addresses in strict program order starting at the
    // reset PC; a taken branch restarts the stream at the aligned target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        pend;
        logic [31:0] pend_addr;
        int          taken;
        do_reset();
        exp_pc = 32'h0;
        pend = 1'b0;
        pend_addr = '0;
        taken = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            ready = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 30);
            bv    = ($urandom_range(0, 99) < 8);
            bt    = $urandom_range(0, 1) == 1;
            btgt  = $urandom & 32'h0000_FFFF;
            smp();
            n_chk++;
            if (fl0 !== (bv & bt)) begin
                n_fail++;
                $display("FAIL rnd_flush c%0d: got %b want %b", c, fl0, bv & bt);
            end
            if (pend) begin
                n_chk++;
                if ({req0, addr0} !== {1'b1, pend_addr}) begin
                    n_fail++;
                    $display("FAIL rnd_stable c%0d: got req=%b addr=%h want 1/%h",
                             c, req0, addr0, pend_addr);
                end
            end
            if (req0 === 1'b1) begin
                n_chk++;
                if (addr0[1:0] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rnd_align c%0d: got addr=%h want aligned", c, addr0);
                end
            end
            if (bv && bt) begin
                exp_pc = btgt & ~32'h3;
            end else if (v0 === 1'b1 && !stall) begin
                n_chk++;
                if ({pc0, ins0} !== {exp_pc, memf(exp_pc)}) begin
                    n_fail++;
                    $display("FAIL rnd_order c%0d: got pc=%h ins=%h want %h/%h",
                             c, pc0, ins0, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                taken++;
            end
            pend = req0 & ~ready;
            pend_addr = addr0;
        end
        bv = 1'b0; bt = 1'b0;
        n_chk++;
        if (taken < 200) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d consumed want >= 200", taken);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_drop();
        test_redirect_blocked();
        test_latency();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
